// File: rtl/wqe_ptr_requester_if.sv
// Handshake bundle around the WQE pointer requester.
// The master modport is the requester itself; slave is the scheduler/allocator/consumer side.
interface wqe_ptr_requester_if #(
  parameter int WQE_INDEX_WIDTH   = 10,
  parameter int WQE_SOURCE_LENGTH = 11
) ();
  logic                         s_axis_req_valid;
  logic                         s_axis_req_ready;
  logic [WQE_INDEX_WIDTH-1:0]   s_axis_req_id;

  logic                         m_axis_Ptrapply_valid;
  logic                         m_axis_Ptrapply_ready;
  logic [WQE_INDEX_WIDTH-1:0]   m_axis_Ptrapply_id;

  logic                         s_axis_Pallocate_valid;
  logic                         s_axis_Pallocate_ready;
  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Pallocate_id;
  logic [WQE_SOURCE_LENGTH-1:0] s_axis_Pallocate_ptr;

  logic                         m_axis_grant_valid;
  logic                         m_axis_grant_ready;
  logic [WQE_INDEX_WIDTH-1:0]   m_axis_grant_id;
  logic [WQE_SOURCE_LENGTH-1:0] m_axis_grant_ptr;

  logic                         s_axis_done_valid;
  logic                         s_axis_done_ready;
  logic [WQE_INDEX_WIDTH-1:0]   s_axis_done_id;

  logic                         m_axis_Brelease_valid;
  logic                         m_axis_Brelease_ready;
  logic [WQE_SOURCE_LENGTH-1:0] m_axis_Brelease_ptr;

  modport master (
    input  s_axis_req_valid, s_axis_req_id,
    output s_axis_req_ready,
    output m_axis_Ptrapply_valid, m_axis_Ptrapply_id,
    input  m_axis_Ptrapply_ready,
    input  s_axis_Pallocate_valid, s_axis_Pallocate_id, s_axis_Pallocate_ptr,
    output s_axis_Pallocate_ready,
    output m_axis_grant_valid, m_axis_grant_id, m_axis_grant_ptr,
    input  m_axis_grant_ready,
    input  s_axis_done_valid, s_axis_done_id,
    output s_axis_done_ready,
    output m_axis_Brelease_valid, m_axis_Brelease_ptr,
    input  m_axis_Brelease_ready
  );

  modport slave (
    output s_axis_req_valid, s_axis_req_id,
    input  s_axis_req_ready,
    input  m_axis_Ptrapply_valid, m_axis_Ptrapply_id,
    output m_axis_Ptrapply_ready,
    output s_axis_Pallocate_valid, s_axis_Pallocate_id, s_axis_Pallocate_ptr,
    input  s_axis_Pallocate_ready,
    input  m_axis_grant_valid, m_axis_grant_id, m_axis_grant_ptr,
    output m_axis_grant_ready,
    output s_axis_done_valid, s_axis_done_id,
    input  s_axis_done_ready,
    input  m_axis_Brelease_valid, m_axis_Brelease_ptr,
    output m_axis_Brelease_ready
  );
endinterface

// File: rtl/wqe_ptr_requester.sv
// Client front end of the WQE buffer-pointer pool: applies, grants, tracks ownership, releases.
// Optional statistics counters are built only when WQE_PTR_REQ_STATS_EN is defined.
module wqe_ptr_requester #(
  parameter int WQE_INDEX_WIDTH   = 10,
  parameter int WQE_SOURCE_LENGTH = 11
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  wqe_ptr_requester_if.master          bus,
  output logic                         err_id_mismatch,
  output logic                         err_done_unowned,
  output logic [WQE_SOURCE_LENGTH:0]   stat_inflight,
  output logic [31:0]                  stat_grant_cnt
);
  localparam int IDX   = WQE_INDEX_WIDTH;
  localparam int SRC   = WQE_SOURCE_LENGTH;
  localparam int DEPTH = 1 << IDX;

  localparam logic [1:0] A_IDLE  = 2'd0;
  localparam logic [1:0] A_APPLY = 2'd1;
  localparam logic [1:0] A_WAIT  = 2'd2;
  localparam logic [1:0] A_GRANT = 2'd3;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_LOOK  = 2'd1;
  localparam logic [1:0] R_SEND  = 2'd2;

  logic [1:0]     a_state;
  logic [IDX-1:0] a_id;
  logic [SRC-1:0] a_ptr;
  logic [1:0]     r_state;
  logic [IDX-1:0] r_id;
  logic           run;

  // Ownership bits live in flops so reset can clear them in one cycle;
  // the pointers themselves sit in block RAM.
  logic [DEPTH-1:0] vld;
  logic [SRC-1:0]   ptr_mem [DEPTH];
  logic [SRC-1:0]   ptr_rd;

  logic req_xfer, apply_xfer, alloc_xfer, grant_xfer, done_xfer, brel_xfer, rd_en;

  // run keeps every ready low while reset is held and for the first cycle after it
  assign bus.s_axis_req_ready       = run && (a_state == A_IDLE) && !vld[bus.s_axis_req_id];
  assign bus.m_axis_Ptrapply_valid  = (a_state == A_APPLY);
  assign bus.m_axis_Ptrapply_id     = a_id;
  assign bus.s_axis_Pallocate_ready = (a_state == A_WAIT);
  assign bus.m_axis_grant_valid     = (a_state == A_GRANT);
  assign bus.m_axis_grant_id        = a_id;
  assign bus.m_axis_grant_ptr       = a_ptr;
  assign bus.s_axis_done_ready      = run && (r_state == R_IDLE);
  assign bus.m_axis_Brelease_valid  = (r_state == R_SEND);
  assign bus.m_axis_Brelease_ptr    = ptr_rd;

  assign req_xfer   = bus.s_axis_req_valid       && bus.s_axis_req_ready;
  assign apply_xfer = bus.m_axis_Ptrapply_valid  && bus.m_axis_Ptrapply_ready;
  assign alloc_xfer = bus.s_axis_Pallocate_valid && bus.s_axis_Pallocate_ready;
  assign grant_xfer = bus.m_axis_grant_valid     && bus.m_axis_grant_ready;
  assign done_xfer  = bus.s_axis_done_valid      && bus.s_axis_done_ready;
  assign brel_xfer  = bus.m_axis_Brelease_valid  && bus.m_axis_Brelease_ready;
  assign rd_en      = (r_state == R_LOOK) && vld[r_id];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      run              <= 1'b0;
      a_state          <= A_IDLE;
      a_id             <= '0;
      a_ptr            <= '0;
      r_state          <= R_IDLE;
      r_id             <= '0;
      vld              <= '0;
      err_id_mismatch  <= 1'b0;
      err_done_unowned <= 1'b0;
    end else begin
      run <= 1'b1;
      case (a_state)
        A_IDLE:  if (req_xfer) begin
                   a_id    <= bus.s_axis_req_id;
                   a_state <= A_APPLY;
                 end
        A_APPLY: if (apply_xfer) a_state <= A_WAIT;
        A_WAIT:  if (alloc_xfer) begin
                   a_ptr   <= bus.s_axis_Pallocate_ptr;
                   a_state <= A_GRANT;
                   if (bus.s_axis_Pallocate_id != a_id) err_id_mismatch <= 1'b1;
                 end
        default: if (grant_xfer) begin
                   vld[a_id] <= 1'b1;
                   a_state   <= A_IDLE;
                 end
      endcase
      // A_GRANT never targets an owned id, so this clear cannot collide with the set above
      case (r_state)
        R_IDLE:  if (done_xfer) begin
                   r_id    <= bus.s_axis_done_id;
                   r_state <= R_LOOK;
                 end
        R_LOOK:  if (vld[r_id]) begin
                   vld[r_id] <= 1'b0;
                   r_state   <= R_SEND;
                 end else begin
                   err_done_unowned <= 1'b1;
                   r_state          <= R_IDLE;
                 end
        default: if (brel_xfer) r_state <= R_IDLE;
      endcase
    end
  end

  // Pointer read happens in R_LOOK so a grant written the cycle before is already visible
  always_ff @(posedge sys_clk) begin
    if (grant_xfer) ptr_mem[a_id] <= a_ptr;
    if (rd_en)      ptr_rd        <= ptr_mem[r_id];
  end

`ifdef WQE_PTR_REQ_STATS_EN
  logic [SRC:0] inflight;
  logic [31:0]  grant_cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      inflight  <= '0;
      grant_cnt <= '0;
    end else begin
      if (grant_xfer && !brel_xfer)      inflight <= inflight + 1'b1;
      else if (!grant_xfer && brel_xfer) inflight <= inflight - 1'b1;
      if (grant_xfer) grant_cnt <= grant_cnt + 32'd1;
    end
  end

  assign stat_inflight  = inflight;
  assign stat_grant_cnt = grant_cnt;
`else
  assign stat_inflight  = '0;
  assign stat_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_wqe_ptr_requester.sv
// Directed plus randomized bench for wqe_ptr_requester; the bench plays scheduler,
// allocator and consumer and predicts outputs from an id->pointer ownership model.
module tb_wqe_ptr_requester;
  localparam int IDX = 10;
  localparam int SRC = 11;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic           err_id_mismatch, err_done_unowned;
  logic [SRC:0]   stat_inflight;
  logic [31:0]    stat_grant_cnt;

  wqe_ptr_requester_if #(.WQE_INDEX_WIDTH(IDX), .WQE_SOURCE_LENGTH(SRC)) bus ();

  wqe_ptr_requester #(.WQE_INDEX_WIDTH(IDX), .WQE_SOURCE_LENGTH(SRC)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .bus              (bus),
    .err_id_mismatch  (err_id_mismatch),
    .err_done_unowned (err_done_unowned),
    .stat_inflight    (stat_inflight),
    .stat_grant_cnt   (stat_grant_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int passes = 0;
  int fails = 0;

  // Reference model: pointers the client currently owns, plus expected flags/stats
  logic [SRC-1:0] own [int];
  int             exp_inflight = 0;
  int unsigned    exp_gcnt = 0;
  logic           exp_err_mm = 1'b0;
  logic           exp_err_un = 1'b0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef WQE_PTR_REQ_STATS_EN
    chk({tag, "_inflight"}, 64'(stat_inflight), 64'(exp_inflight));
    chk({tag, "_grant_cnt"}, 64'(stat_grant_cnt), 64'(exp_gcnt));
`else
    chk({tag, "_inflight"}, 64'(stat_inflight), 64'd0);
    chk({tag, "_grant_cnt"}, 64'(stat_grant_cnt), 64'd0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.s_axis_req_ready), 64'd0);
    chk({tag, "_apply_valid"}, 64'(bus.m_axis_Ptrapply_valid), 64'd0);
    chk({tag, "_alloc_ready"}, 64'(bus.s_axis_Pallocate_ready), 64'd0);
    chk({tag, "_grant_valid"}, 64'(bus.m_axis_grant_valid), 64'd0);
    chk({tag, "_done_ready"}, 64'(bus.s_axis_done_ready), 64'd0);
    chk({tag, "_brel_valid"}, 64'(bus.m_axis_Brelease_valid), 64'd0);
    chk({tag, "_err_mm"}, 64'(err_id_mismatch), 64'd0);
    chk({tag, "_err_un"}, 64'(err_done_unowned), 64'd0);
    chk({tag, "_inflight"}, 64'(stat_inflight), 64'd0);
    chk({tag, "_grant_cnt"}, 64'(stat_grant_cnt), 64'd0);
  endtask

  task automatic do_req(input logic [IDX-1:0] id);
    bit ok;
    ok = 1'b0;
    bus.s_axis_req_valid = 1'b1;
    bus.s_axis_req_id    = id;
    #1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = bus.s_axis_req_ready;
      tick();
    end
    bus.s_axis_req_valid = 1'b0;
    chk("req_accept", 64'(ok), 64'd1);
  endtask

  task automatic apply_accept(input logic [IDX-1:0] exp_id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = bus.m_axis_Ptrapply_valid;
      if (!ok) tick();
    end
    chk("apply_valid", 64'(ok), 64'd1);
    chk("apply_id", 64'(bus.m_axis_Ptrapply_id), 64'(exp_id));
    bus.m_axis_Ptrapply_ready = 1'b1;
    tick();
    bus.m_axis_Ptrapply_ready = 1'b0;
    chk("apply_drop", 64'(bus.m_axis_Ptrapply_valid), 64'd0);
  endtask

  task automatic alloc_grant(input logic [IDX-1:0] exp_id, input logic [IDX-1:0] ret_id,
                             input logic [SRC-1:0] ptr, input int delay);
    bit ok;
    ok = 1'b0;
    repeat (delay) tick();
    bus.s_axis_Pallocate_valid = 1'b1;
    bus.s_axis_Pallocate_id    = ret_id;
    bus.s_axis_Pallocate_ptr   = ptr;
    #1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = bus.s_axis_Pallocate_ready;
      tick();
    end
    bus.s_axis_Pallocate_valid = 1'b0;
    chk("alloc_accept", 64'(ok), 64'd1);
    if (ret_id != exp_id) exp_err_mm = 1'b1;
  endtask

  task automatic wait_grant(input logic [IDX-1:0] exp_id, input logic [SRC-1:0] exp_ptr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = bus.m_axis_grant_valid;
      if (!ok) tick();
    end
    chk("grant_valid", 64'(ok), 64'd1);
    chk("grant_id", 64'(bus.m_axis_grant_id), 64'(exp_id));
    chk("grant_ptr", 64'(bus.m_axis_grant_ptr), 64'(exp_ptr));
    chk("err_id_mismatch", 64'(err_id_mismatch), 64'(exp_err_mm));
  endtask

  task automatic take_grant(input logic [IDX-1:0] exp_id, input logic [SRC-1:0] exp_ptr,
                            input int rdelay);
    wait_grant(exp_id, exp_ptr);
    repeat (rdelay) begin
      tick();
      chk("grant_hold", 64'({bus.m_axis_grant_valid, bus.m_axis_grant_id, bus.m_axis_grant_ptr}),
          64'({1'b1, exp_id, exp_ptr}));
    end
    bus.m_axis_grant_ready = 1'b1;
    tick();
    bus.m_axis_grant_ready = 1'b0;
    own[int'(exp_id)] = exp_ptr;
    exp_inflight++;
    exp_gcnt++;
    chk("grant_once", 64'(bus.m_axis_grant_valid), 64'd0);
    chk_stats("grant");
  endtask

  task automatic take_brel(input logic [SRC-1:0] p, input int hold);
    chk("brel_valid", 64'(bus.m_axis_Brelease_valid), 64'd1);
    chk("brel_ptr", 64'(bus.m_axis_Brelease_ptr), 64'(p));
    repeat (hold) begin
      tick();
      chk("brel_hold", 64'({bus.m_axis_Brelease_valid, bus.m_axis_Brelease_ptr}), 64'({1'b1, p}));
    end
    bus.m_axis_Brelease_ready = 1'b1;
    tick();
    bus.m_axis_Brelease_ready = 1'b0;
    exp_inflight--;
    chk("brel_once", 64'(bus.m_axis_Brelease_valid), 64'd0);
    chk_stats("brel");
  endtask

  // leave=1 stops with the Brelease still pending so the caller can finish it
  task automatic done_op(input logic [IDX-1:0] id, input int hold, input bit leave);
    bit ok;
    bit owned;
    logic [SRC-1:0] p;
    ok    = 1'b0;
    owned = own.exists(int'(id));
    p     = owned ? own[int'(id)] : '0;
    bus.s_axis_done_valid = 1'b1;
    bus.s_axis_done_id    = id;
    #1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = bus.s_axis_done_ready;
      tick();
    end
    bus.s_axis_done_valid = 1'b0;
    chk("done_accept", 64'(ok), 64'd1);
    chk("look_no_brel", 64'(bus.m_axis_Brelease_valid), 64'd0);
    chk("look_done_busy", 64'(bus.s_axis_done_ready), 64'd0);
    tick();
    if (owned) begin
      own.delete(int'(id));
      if (leave) begin
        chk("brel_valid", 64'(bus.m_axis_Brelease_valid), 64'd1);
        chk("brel_ptr", 64'(bus.m_axis_Brelease_ptr), 64'(p));
      end else begin
        take_brel(p, hold);
      end
    end else begin
      exp_err_un = 1'b1;
      chk("unowned_no_brel", 64'(bus.m_axis_Brelease_valid), 64'd0);
      chk("unowned_done_ready", 64'(bus.s_axis_done_ready), 64'd1);
    end
    chk("err_done_unowned", 64'(err_done_unowned), 64'(exp_err_un));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDX-1:0] rid;
    logic [IDX-1:0] ret;
    logic [SRC-1:0] rptr;

    bus.s_axis_req_valid       = 1'b0;
    bus.s_axis_req_id          = '0;
    bus.m_axis_Ptrapply_ready  = 1'b0;
    bus.s_axis_Pallocate_valid = 1'b0;
    bus.s_axis_Pallocate_id    = '0;
    bus.s_axis_Pallocate_ptr   = '0;
    bus.m_axis_grant_ready     = 1'b0;
    bus.s_axis_done_valid      = 1'b0;
    bus.s_axis_done_id         = '0;
    bus.m_axis_Brelease_ready  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    sys_rst_n = 1'b1;
    tick();

    // Request id 5, allocator answers (5, 0x012) after two cycles
    do_req(10'd5);
    apply_accept(10'd5);
    alloc_grant(10'd5, 10'd5, 11'h012, 2);
    take_grant(10'd5, 11'h012, 0);

    // Re-request of an owned id stalls until the done for it clears ownership
    bus.s_axis_req_valid = 1'b1;
    bus.s_axis_req_id    = 10'd5;
    #1;
    chk("owned_req_stall0", 64'(bus.s_axis_req_ready), 64'd0);
    tick();
    chk("owned_req_stall1", 64'(bus.s_axis_req_ready), 64'd0);
    done_op(10'd5, 0, 1'b1);
    chk("owned_req_released", 64'(bus.s_axis_req_ready), 64'd1);
    tick();
    bus.s_axis_req_valid = 1'b0;
    chk("stalled_req_applied", 64'(bus.m_axis_Ptrapply_valid), 64'd1);
    take_brel(11'h012, 4);
    apply_accept(10'd5);
    alloc_grant(10'd5, 10'd5, 11'h2A5, 0);
    take_grant(10'd5, 11'h2A5, 1);

    // Done for an id that was never granted
    done_op(10'd7, 0, 1'b0);

    // Allocator answers with the wrong id: error raised, grant keeps the applied id
    do_req(10'd3);
    apply_accept(10'd3);
    alloc_grant(10'd3, 10'd6, 11'h155, 1);
    take_grant(10'd3, 11'h155, 0);

    // Grant and Brelease transfer on the same edge
    done_op(10'd3, 0, 1'b1);
    do_req(10'd9);
    apply_accept(10'd9);
    alloc_grant(10'd9, 10'd9, 11'h0AB, 1);
    wait_grant(10'd9, 11'h0AB);
    chk("brel_still_pending", 64'(bus.m_axis_Brelease_ptr), 64'h155);
    bus.m_axis_grant_ready    = 1'b1;
    bus.m_axis_Brelease_ready = 1'b1;
    tick();
    bus.m_axis_grant_ready    = 1'b0;
    bus.m_axis_Brelease_ready = 1'b0;
    own[9] = 11'h0AB;
    exp_gcnt++;
    chk("same_edge_valids", 64'({bus.m_axis_grant_valid, bus.m_axis_Brelease_valid}), 64'd0);
    chk_stats("same_edge");

    // Randomized traffic over a small id range so ownership collisions are frequent
    for (int n = 0; n < 40; n++) begin
      rid = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 2) begin
        if (own.exists(int'(rid))) begin
          bus.s_axis_req_id = rid;
          #1;
          chk("rand_req_stall", 64'(bus.s_axis_req_ready), 64'd0);
          tick();
        end else begin
          rptr = 11'($urandom_range(0, 2047));
          ret  = ($urandom_range(0, 7) == 0) ? (rid ^ 10'd1) : rid;
          do_req(rid);
          apply_accept(rid);
          alloc_grant(rid, ret, rptr, int'($urandom_range(0, 3)));
          take_grant(rid, rptr, int'($urandom_range(0, 2)));
        end
      end else begin
        done_op(rid, int'($urandom_range(0, 3)), 1'b0);
        chk_stats("rand_done");
      end
    end

    // Reset while waiting for the allocator drops everything
    do_req(10'd100);
    apply_accept(10'd100);
    chk("in_wait", 64'(bus.s_axis_Pallocate_ready), 64'd1);
    sys_rst_n = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    own.delete();
    exp_inflight = 0;
    exp_gcnt     = 0;
    exp_err_mm   = 1'b0;
    exp_err_un   = 1'b0;
    sys_rst_n = 1'b1;
    tick();
    tick();
    bus.s_axis_req_id = 10'd5;
    #1;
    chk("table_cleared", 64'(bus.s_axis_req_ready), 64'd1);
    tick();
    done_op(10'd5, 0, 1'b0);
    chk_stats("post_reset");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
